// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Control outputs are bundled into one struct so each pipeline situation is a single constant.
package hazard_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MWAIT   = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                 ex_mem_write: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b0,
                                 mem_wb_bubble: 1'b0};
  localparam ctrl_t CTRL_LOAD = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b1,
                                  ex_mem_write: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b1,
                                  mem_wb_bubble: 1'b0};
  localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                    ex_mem_write: 1'b1, if_id_flush: 1'b1, id_ex_bubble: 1'b1,
                                    mem_wb_bubble: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
                                    ex_mem_write: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b0,
                                    mem_wb_bubble: 1'b1};
  localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
                                   ex_mem_write: 1'b0, if_id_flush: 1'b1, id_ex_bubble: 1'b1,
                                   mem_wb_bubble: 1'b1};

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the stall, flush and memory-wait counts.
module hazard_sat_counter
  import hazard_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, data-memory freeze,
// taken-branch squash, plus sticky timeout and saturating stall/flush diagnostics.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int LOAD_STALLS = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_EX_memRead,
  input  logic [4:0]       ID_EX_rt,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic             IF_ID_usesRt,
  input  logic             branchTaken,
  input  logic             EX_MEM_memReq,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             MEM_WB_bubble,
  output logic             memTimeout,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  localparam logic [2:0]       LD_INIT    = 3'(LOAD_STALLS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state, state_n;
  logic [2:0]       ld_cnt, ld_cnt_n;
  logic             resume_ld, resume_ld_n;
  logic             mem_busy, load_use, eff_load_use, flush_evt;
  logic [CNT_W-1:0] wait_cnt;
  ctrl_t            ctrl, ctrl_out;

  assign mem_busy = EX_MEM_memReq && !memReady;
  assign load_use = ID_EX_memRead && (ID_EX_rt != 5'd0) &&
                    ((ID_EX_rt == IF_ID_rs) || (IF_ID_usesRt && (ID_EX_rt == IF_ID_rt)));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ctrl         = CTRL_RUN;
    state_n      = state;
    ld_cnt_n     = ld_cnt;
    resume_ld_n  = resume_ld;
    flush_evt    = 1'b0;
    eff_load_use = 1'b0;
    if (mem_busy) begin
      ctrl        = CTRL_FREEZE;
      state_n     = MWAIT;
      resume_ld_n = resume_ld || (state == LDSTALL) || load_use;
    end else if (state == LDSTALL) begin
      ctrl = CTRL_LOAD;
      if (ld_cnt <= 3'd1) begin
        state_n  = RUN;
        ld_cnt_n = 3'd0;
      end else begin
        ld_cnt_n = ld_cnt - 3'd1;
      end
    end else begin
      // RUN rules; an MWAIT exit also replays a load-use that was frozen before its bubble.
      eff_load_use = load_use || ((state == MWAIT) && resume_ld && (ld_cnt == 3'd0));
      state_n      = RUN;
      if (branchTaken) begin
        ctrl      = CTRL_BRANCH;
        flush_evt = 1'b1;
      end else if (eff_load_use) begin
        ctrl = CTRL_LOAD;
        if (LOAD_STALLS > 1) begin
          state_n  = LDSTALL;
          ld_cnt_n = LD_INIT;
        end
      end
      if (state == MWAIT) begin
        resume_ld_n = 1'b0;
        if (resume_ld && (ld_cnt != 3'd0)) begin
          state_n  = LDSTALL;
          ld_cnt_n = ld_cnt;
        end
      end
    end
  end

  assign ctrl_out      = rst_n ? ctrl : CTRL_RESET;
  assign pcWrite       = ctrl_out.pc_write;
  assign IF_ID_write   = ctrl_out.if_id_write;
  assign ID_EX_write   = ctrl_out.id_ex_write;
  assign EX_MEM_write  = ctrl_out.ex_mem_write;
  assign IF_ID_flush   = ctrl_out.if_id_flush;
  assign ID_EX_bubble  = ctrl_out.id_ex_bubble;
  assign MEM_WB_bubble = ctrl_out.mem_wb_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      ld_cnt     <= 3'd0;
      resume_ld  <= 1'b0;
      memTimeout <= 1'b0;
    end else begin
      state     <= state_n;
      ld_cnt    <= ld_cnt_n;
      resume_ld <= resume_ld_n;
      // Sets on the edge where the wait count reaches the limit.
      if (mem_busy && (wait_cnt >= TIMEOUT_M1)) begin
        memTimeout <= 1'b1;
      end
    end
  end

  hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!ctrl.pc_write),
    .clr   (1'b0),
    .count (stallCount)
  );

  hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_evt),
    .clr   (1'b0),
    .count (flushCount)
  );

  hazard_sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mem_busy),
    .clr   (!mem_busy),
    .count (wait_cnt)
  );

  // A branch cannot resolve in EX while a load-use bubble occupies it.
  a_no_branch_in_ldstall : assert property (@(posedge clk) disable iff (!rst_n)
                                            !((state == LDSTALL) && branchTaken));

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: one instance with LOAD_STALLS=1/MEM_TIMEOUT=3,
// one with LOAD_STALLS=3/MEM_TIMEOUT=255, both driven by the same stimulus.
module tb_hazard_controller;
  import hazard_pkg::*;

  localparam logic [6:0] C_DEF  = 7'b1111_000;
  localparam logic [6:0] C_LOAD = 7'b0011_010;
  localparam logic [6:0] C_BR   = 7'b1111_110;
  localparam logic [6:0] C_FRZ  = 7'b0000_001;
  localparam logic [6:0] C_RST  = 7'b0000_111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ID_EX_memRead, IF_ID_usesRt, branchTaken, EX_MEM_memReq, memReady;
  logic [4:0] ID_EX_rt, IF_ID_rs, IF_ID_rt;

  wire [6:0]  ctrl1, ctrl3;
  wire        mt1, mt3;
  wire [15:0] sc1, fc1, sc3, fc3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_controller #(.LOAD_STALLS(1), .MEM_TIMEOUT(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .ID_EX_memRead(ID_EX_memRead), .ID_EX_rt(ID_EX_rt),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_usesRt(IF_ID_usesRt),
    .branchTaken(branchTaken), .EX_MEM_memReq(EX_MEM_memReq), .memReady(memReady),
    .pcWrite(ctrl1[6]), .IF_ID_write(ctrl1[5]), .ID_EX_write(ctrl1[4]), .EX_MEM_write(ctrl1[3]),
    .IF_ID_flush(ctrl1[2]), .ID_EX_bubble(ctrl1[1]), .MEM_WB_bubble(ctrl1[0]),
    .memTimeout(mt1), .stallCount(sc1), .flushCount(fc1)
  );

  hazard_controller #(.LOAD_STALLS(3), .MEM_TIMEOUT(255)) dut3 (
    .clk(clk), .rst_n(rst_n), .ID_EX_memRead(ID_EX_memRead), .ID_EX_rt(ID_EX_rt),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_usesRt(IF_ID_usesRt),
    .branchTaken(branchTaken), .EX_MEM_memReq(EX_MEM_memReq), .memReady(memReady),
    .pcWrite(ctrl3[6]), .IF_ID_write(ctrl3[5]), .ID_EX_write(ctrl3[4]), .EX_MEM_write(ctrl3[3]),
    .IF_ID_flush(ctrl3[2]), .ID_EX_bubble(ctrl3[1]), .MEM_WB_bubble(ctrl3[0]),
    .memTimeout(mt3), .stallCount(sc3), .flushCount(fc3)
  );

  task automatic idle();
    ID_EX_memRead = 1'b0; ID_EX_rt = 5'd0; IF_ID_rs = 5'd0; IF_ID_rt = 5'd0;
    IF_ID_usesRt = 1'b0; branchTaken = 1'b0; EX_MEM_memReq = 1'b0; memReady = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic set_load_use(input logic [4:0] rt, input logic [4:0] rs);
    idle();
    ID_EX_memRead = 1'b1; ID_EX_rt = rt; IF_ID_rs = rs;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    n_cmp++;
    if (ctrl1 !== C_RST || ctrl3 !== C_RST) begin
      n_bad++; $display("FAIL reset_ctrl: got %b/%b want %b", ctrl1, ctrl3, C_RST);
    end
    n_cmp++;
    if (sc1 !== 16'd0 || fc1 !== 16'd0 || mt1 !== 1'b0) begin
      n_bad++; $display("FAIL reset_regs: stall=%0d flush=%0d to=%b want 0/0/0", sc1, fc1, mt1);
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ctrl1 !== C_DEF) begin
      n_bad++; $display("FAIL reset_release: got %b want %b", ctrl1, C_DEF);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    apply_reset();
    set_load_use(5'd5, 5'd5);
    @(negedge clk);
    n_cmp++;
    if (ctrl1 !== C_LOAD) begin
      n_bad++; $display("FAIL lu_stall: got %b want %b", ctrl1, C_LOAD);
    end
    next_cycle();
    idle();
    @(negedge clk);
    n_cmp++;
    if (ctrl1 !== C_DEF) begin
      n_bad++; $display("FAIL lu_after: got %b want %b", ctrl1, C_DEF);
    end
    n_cmp++;
    if (sc1 !== 16'd1) begin
      n_bad++; $display("FAIL lu_count: got %0d want 1", sc1);
    end
    next_cycle();
  endtask

  task automatic test_no_hazard();
    logic [4:0] rt_v [3] = '{5'd0, 5'd7, 5'd7};
    logic [4:0] rs_v [3] = '{5'd0, 5'd3, 5'd3};
    logic       use_v[3] = '{1'b0, 1'b0, 1'b1};
    logic [6:0] exp_v[3] = '{C_DEF, C_DEF, C_LOAD};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      set_load_use(rt_v[i], rs_v[i]);
      IF_ID_rt     = rt_v[i];
      IF_ID_usesRt = use_v[i];
      @(negedge clk);
      n_cmp++;
      if (ctrl1 !== exp_v[i]) begin
        n_bad++; $display("FAIL nohaz_%0d: got %b want %b", i, ctrl1, exp_v[i]);
      end
      next_cycle();
    end
    idle();
    n_cmp++;
    if (sc1 !== 16'd1) begin
      n_bad++; $display("FAIL nohaz_count: got %0d want 1", sc1);
    end
    next_cycle();
  endtask

  task automatic test_branch_load();
    apply_reset();
    set_load_use(5'd9, 5'd9);
    branchTaken = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ctrl1 !== C_BR) begin
      n_bad++; $display("FAIL br_flush: got %b want %b", ctrl1, C_BR);
    end
    next_cycle();
    idle();
    @(negedge clk);
    n_cmp++;
    if (ctrl1 !== C_DEF) begin
      n_bad++; $display("FAIL br_after: got %b want %b", ctrl1, C_DEF);
    end
    n_cmp++;
    if (fc1 !== 16'd1 || sc1 !== 16'd0) begin
      n_bad++; $display("FAIL br_counts: flush=%0d stall=%0d want 1/0", fc1, sc1);
    end
    next_cycle();
  endtask

  task automatic test_mem_timeout();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      EX_MEM_memReq = 1'b1; memReady = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ctrl1 !== C_FRZ || mt1 !== (i == 3)) begin
        n_bad++; $display("FAIL frz_%0d: ctrl=%b to=%b want %b to=%b", i, ctrl1, mt1, C_FRZ, (i == 3));
      end
      next_cycle();
    end
    memReady = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ctrl1 !== C_DEF || mt1 !== 1'b1) begin
      n_bad++; $display("FAIL frz_release: ctrl=%b to=%b want %b to=1", ctrl1, mt1, C_DEF);
    end
    next_cycle();
    idle();
    @(negedge clk);
    n_cmp++;
    if (sc1 !== 16'd4 || mt1 !== 1'b1) begin
      n_bad++; $display("FAIL frz_after: stall=%0d to=%b want 4/1", sc1, mt1);
    end
    next_cycle();
  endtask

  task automatic test_busy_branch();
    apply_reset();
    branchTaken = 1'b1; EX_MEM_memReq = 1'b1; memReady = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ctrl1 !== C_FRZ) begin
      n_bad++; $display("FAIL bb_freeze: got %b want %b", ctrl1, C_FRZ);
    end
    next_cycle();
    memReady = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ctrl1 !== C_BR) begin
      n_bad++; $display("FAIL bb_flush: got %b want %b", ctrl1, C_BR);
    end
    next_cycle();
    idle();
    n_cmp++;
    if (fc1 !== 16'd1 || sc1 !== 16'd1) begin
      n_bad++; $display("FAIL bb_counts: flush=%0d stall=%0d want 1/1", fc1, sc1);
    end
    next_cycle();
  endtask

  task automatic test_load_stall3();
    logic [6:0] exp_v[4] = '{C_LOAD, C_LOAD, C_LOAD, C_DEF};
    apply_reset();
    set_load_use(5'd4, 5'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ctrl3 !== exp_v[i]) begin
        n_bad++; $display("FAIL ls3_%0d: got %b want %b", i, ctrl3, exp_v[i]);
      end
      next_cycle();
      idle();
    end
    n_cmp++;
    if (sc3 !== 16'd3) begin
      n_bad++; $display("FAIL ls3_count: got %0d want 3", sc3);
    end
  endtask

  task automatic test_ldstall_freeze();
    // Detection, freeze in the first LDSTALL cycle for 2 cycles, release, then the
    // interrupted LDSTALL sequence replays from its held count.
    logic [6:0] exp_v[7] = '{C_LOAD, C_FRZ, C_FRZ, C_DEF, C_LOAD, C_LOAD, C_DEF};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      idle();
      if (i == 0) set_load_use(5'd6, 5'd6);
      if (i == 1 || i == 2) begin
        EX_MEM_memReq = 1'b1; memReady = 1'b0;
      end
      @(negedge clk);
      n_cmp++;
      if (ctrl3 !== exp_v[i]) begin
        n_bad++; $display("FAIL lsf_%0d: got %b want %b", i, ctrl3, exp_v[i]);
      end
      next_cycle();
    end
    idle();
    n_cmp++;
    if (sc3 !== 16'd5) begin
      n_bad++; $display("FAIL lsf_count: got %0d want 5", sc3);
    end
    n_cmp++;
    if (dut3.state !== RUN || dut3.ld_cnt !== 3'd0) begin
      n_bad++; $display("FAIL lsf_state: state=%0d ld_cnt=%0d want 0/0", dut3.state, dut3.ld_cnt);
    end
  endtask

  task automatic test_reset_mid_mwait();
    apply_reset();
    EX_MEM_memReq = 1'b1; memReady = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ctrl1 !== C_RST || sc1 !== 16'd0) begin
      n_bad++; $display("FAIL rmw_assert: ctrl=%b stall=%0d want %b/0", ctrl1, sc1, C_RST);
    end
    next_cycle();
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    n_cmp++;
    if (ctrl1 !== C_DEF || dut1.state !== RUN) begin
      n_bad++; $display("FAIL rmw_release: ctrl=%b state=%0d want %b/0", ctrl1, dut1.state, C_DEF);
    end
    next_cycle();
    n_cmp++;
    if (sc1 !== 16'd0 || fc1 !== 16'd0 || mt1 !== 1'b0 || dut1.wait_cnt !== 16'd0) begin
      n_bad++; $display("FAIL rmw_regs: stall=%0d flush=%0d to=%b wait=%0d want all 0",
                        sc1, fc1, mt1, dut1.wait_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_load();
    test_mem_timeout();
    test_busy_branch();
    test_load_stall3();
    test_ldstall_freeze();
    test_reset_mid_mwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
